// File: rtl/fc_sequencer.sv
// fc_sequencer: walks the weight memory in neuron-major order, issuing one
// READ_SET-wide word per cycle, and delays each read's control tag by
// MEM_LATENCY so the MAC array sees clear/last/in_sel/lane_mask aligned with
// the returned weight data.
// Optional feature: define FC_BIAS_EN to prepend one bias word per neuron.
module fc_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int INPUT_MAP   = 400,
    parameter int OUTPUT_MAP  = 120,
    parameter int READ_SET    = 16,
    parameter int ADDR_WIDTH  = 12,
    parameter int MEM_LATENCY = 2,
    localparam int CHUNKS = (INPUT_MAP + READ_SET - 1) / READ_SET,
    localparam int SEL_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
    localparam int IDX_W  = (OUTPUT_MAP > 1) ? $clog2(OUTPUT_MAP) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  hold,
    output logic [ADDR_WIDTH-1:0] weight_rd_addr,
    output logic                  weight_rd_en,
    output logic                  mac_valid,
    output logic                  mac_clear,
    output logic                  mac_last,
    output logic [SEL_W-1:0]      in_sel,
    output logic [READ_SET-1:0]   lane_mask,
    output logic                  out_valid,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  busy,
    output logic                  done
);

`ifdef FC_BIAS_EN
    localparam int BIAS = 1;
`else
    localparam int BIAS = 0;
`endif
    localparam int WORDS      = CHUNKS + BIAS;
    localparam int WORD_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LAST_LANES = INPUT_MAP - (CHUNKS - 1) * READ_SET;
    localparam logic [READ_SET-1:0] FULL_MASK = '1;
    localparam logic [READ_SET-1:0] LAST_MASK = FULL_MASK >> (READ_SET - LAST_LANES);
    localparam logic [READ_SET-1:0] BIAS_MASK = READ_SET'(1);

    // Elaboration-time sanity on the configuration.
    if (MEM_LATENCY < 1) begin : g_chk_lat
        $error("fc_sequencer: MEM_LATENCY must be at least 1");
    end
    if (OUTPUT_MAP * WORDS > (1 << ADDR_WIDTH)) begin : g_chk_addr
        $error("fc_sequencer: weight words do not fit in ADDR_WIDTH");
    end
    if (DATA_WIDTH < 1) begin : g_chk_dw
        $error("fc_sequencer: DATA_WIDTH must be positive");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    // Control carried alongside each read through the latency pipe.
    typedef struct packed {
        logic                clear;
        logic                last;
        logic [SEL_W-1:0]    sel;
        logic [IDX_W-1:0]    neuron;
        logic [READ_SET-1:0] mask;
    } tag_t;

    state_t                state_q, state_n;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_W-1:0]     word_q;
    logic [IDX_W-1:0]      neuron_q;
    logic                  word_wrap, last_read;
    tag_t                  tag0;
    logic [MEM_LATENCY:1]  vld_pipe;
    tag_t                  tag_pipe [MEM_LATENCY:1];

    assign word_wrap = (word_q == WORD_W'(WORDS - 1));
    assign last_read = word_wrap && (neuron_q == IDX_W'(OUTPUT_MAP - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    // Next-state and read-enable decode.
    always_comb begin
        state_n = state_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE:  if (start) state_n = ISSUE;
            ISSUE: begin
                if (!hold) begin
                    rd_en = 1'b1;
                    if (last_read) state_n = DRAIN;
                end
            end
            // Final neuron's result marks an empty pipe: nothing is issued after it.
            DRAIN: if (vld_pipe == '0 && out_valid && out_idx == IDX_W'(OUTPUT_MAP - 1))
                       state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Running address plus word/neuron counters; address never needs a multiply.
    always_ff @(posedge clk) begin
        if (rst || (state_q == IDLE && start)) begin
            addr_q   <= '0;
            word_q   <= '0;
            neuron_q <= '0;
        end else if (rd_en) begin
            addr_q <= addr_q + 1'b1;
            if (word_wrap) begin
                word_q   <= '0;
                neuron_q <= neuron_q + 1'b1;
            end else begin
                word_q <= word_q + 1'b1;
            end
        end
    end

    // Tag for the read issued this cycle; zero when nothing is issued.
    always_comb begin
        tag0 = '0;
        if (rd_en) begin
            tag0.clear  = (word_q == '0);
            tag0.last   = word_wrap;
            tag0.neuron = neuron_q;
            tag0.sel    = SEL_W'(word_q - WORD_W'(BIAS));
            tag0.mask   = FULL_MASK;
            if (BIAS != 0 && word_q == '0) begin
                tag0.sel  = '0;
                tag0.mask = BIAS_MASK;
            end else if (word_wrap) begin
                tag0.mask = LAST_MASK;
            end
        end
    end

    // Latency-matching shift register for valid and tag; reset flushes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int k = 1; k <= MEM_LATENCY; k++) tag_pipe[k] <= '0;
        end else begin
            vld_pipe[1] <= rd_en;
            tag_pipe[1] <= tag0;
            for (int k = 2; k <= MEM_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    // Accumulator result is final one cycle after the last chunk lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            out_valid <= mac_valid && mac_last;
            out_idx   <= (mac_valid && mac_last) ? tag_pipe[MEM_LATENCY].neuron : '0;
        end
    end

    assign weight_rd_en   = rd_en;
    assign weight_rd_addr = rd_en ? addr_q : '0;
    assign mac_valid      = vld_pipe[MEM_LATENCY];
    assign mac_clear      = tag_pipe[MEM_LATENCY].clear;
    assign mac_last       = tag_pipe[MEM_LATENCY].last;
    assign in_sel         = tag_pipe[MEM_LATENCY].sel;
    assign lane_mask      = tag_pipe[MEM_LATENCY].mask;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);

endmodule

// File: tb/tb_fc_sequencer.sv
// Bench for fc_sequencer: a cycle-level scoreboard (read index counter plus
// a queue of in-flight reads) predicts every output; two DUT instances cover
// the default sizes and a small 20/16/2 configuration with latency 3.
module tb_fc_sequencer;
`ifdef FC_BIAS_EN
    localparam int BIAS = 1;
`else
    localparam int BIAS = 0;
`endif
    localparam int DONE_T = 3004 + 120 * BIAS;

    typedef struct packed {
        logic        rd;
        logic [11:0] addr;
        logic        mv, clr, last;
        logic [7:0]  sel;
        logic [15:0] mask;
        logic        ov;
        logic [7:0]  oidx;
        logic        busy, done;
    } obs_t;

    logic clk = 1'b0;
    logic rst, start, hold;
    always #5 clk = ~clk;

    logic [11:0] a_addr, b_addr;
    logic        a_rd, a_mv, a_clr, a_last, a_ov, a_busy, a_done;
    logic        b_rd, b_mv, b_clr, b_last, b_ov, b_busy, b_done;
    logic [4:0]  a_sel;
    logic [0:0]  b_sel;
    logic [15:0] a_mask, b_mask;
    logic [6:0]  a_oidx;
    logic [0:0]  b_oidx;

    fc_sequencer dut_a (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .weight_rd_addr(a_addr), .weight_rd_en(a_rd), .mac_valid(a_mv),
        .mac_clear(a_clr), .mac_last(a_last), .in_sel(a_sel), .lane_mask(a_mask),
        .out_valid(a_ov), .out_idx(a_oidx), .busy(a_busy), .done(a_done));

    fc_sequencer #(.INPUT_MAP(20), .OUTPUT_MAP(2), .READ_SET(16),
                   .ADDR_WIDTH(12), .MEM_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .weight_rd_addr(b_addr), .weight_rd_en(b_rd), .mac_valid(b_mv),
        .mac_clear(b_clr), .mac_last(b_last), .in_sel(b_sel), .lane_mask(b_mask),
        .out_valid(b_ov), .out_idx(b_oidx), .busy(b_busy), .done(b_done));

    int   total = 0, bad = 0;
    obs_t exp_o, got;
    bit   use_b;
    int   c_in, c_out, c_rs, c_lat;
    // scoreboard state
    int   cyc = 0, m_k = 0, m_stall = 0, m_ov_at = -1, m_ov_idx = 0, m_done_at = -1;
    bit   m_run = 0;
    int   q_cyc[$], q_idx[$];

    task automatic set_cfg(input bit b);
        use_b = b;
        c_in  = b ? 20 : 400;
        c_out = b ? 2 : 120;
        c_rs  = 16;
        c_lat = b ? 3 : 2;
    endtask

    // Predicts this cycle's outputs, then advances to the next cycle.
    task automatic model_cycle(input bit st, input bit hd, input bit rs);
        int ch, wd, n, idx, w, c;
        ch = (c_in + c_rs - 1) / c_rs;
        wd = ch + BIAS;
        n  = c_out * wd;
        exp_o = '0;
        if (m_run) begin
            exp_o.busy = 1'b1;
            if (m_k < n) begin
                if (hd) m_stall++;
                else begin
                    exp_o.rd   = 1'b1;
                    exp_o.addr = 12'(m_k);
                    q_cyc.push_back(cyc + c_lat);
                    q_idx.push_back(m_k);
                    m_k++;
                end
            end
        end
        if (q_cyc.size() > 0 && q_cyc[0] == cyc) begin
            idx = q_idx.pop_front();
            q_cyc.delete(0);
            w = idx % wd;
            exp_o.mv   = 1'b1;
            exp_o.clr  = (w == 0);
            exp_o.last = (w == wd - 1);
            if (BIAS == 1 && w == 0) begin
                exp_o.sel  = 8'd0;
                exp_o.mask = 16'h0001;
            end else begin
                c = w - BIAS;
                exp_o.sel  = 8'(c);
                exp_o.mask = (c == ch - 1) ? 16'((1 << (c_in - (ch - 1) * c_rs)) - 1) : 16'hFFFF;
            end
            if (w == wd - 1) begin m_ov_at = cyc + 1; m_ov_idx = idx / wd; end
            if (idx == n - 1) m_done_at = cyc + 2;
        end
        if (m_ov_at == cyc) begin exp_o.ov = 1'b1; exp_o.oidx = 8'(m_ov_idx); end
        if (m_run && m_done_at == cyc) exp_o.done = 1'b1;
        if (rs) begin
            m_run = 0; q_cyc.delete(); q_idx.delete(); m_ov_at = -1; m_done_at = -1;
        end else if (exp_o.done) m_run = 0;
        else if (!m_run && st) begin m_run = 1; m_k = 0; m_stall = 0; end
        cyc++;
    endtask

    // Gathers the selected DUT's outputs; qualified fields are zeroed unless
    // the scoreboard expects them to be valid (raw keeps everything).
    function automatic obs_t sample(input bit raw);
        obs_t o;
        o = '0;
        if (!use_b) begin
            o.rd = a_rd; o.addr = a_addr; o.mv = a_mv; o.clr = a_clr; o.last = a_last;
            o.sel = 8'(a_sel); o.mask = a_mask; o.ov = a_ov; o.oidx = 8'(a_oidx);
            o.busy = a_busy; o.done = a_done;
        end else begin
            o.rd = b_rd; o.addr = b_addr; o.mv = b_mv; o.clr = b_clr; o.last = b_last;
            o.sel = 8'(b_sel); o.mask = b_mask; o.ov = b_ov; o.oidx = 8'(b_oidx);
            o.busy = b_busy; o.done = b_done;
        end
        if (!raw) begin
            if (!exp_o.rd) o.addr = '0;
            if (!exp_o.mv) begin o.clr = 0; o.last = 0; o.sel = '0; o.mask = '0; end
            if (!exp_o.ov) o.oidx = '0;
        end
        return o;
    endfunction

    task automatic tick(input bit st, input bit hd, input bit rs, input bit raw);
        @(posedge clk);
        #1;
        start = st; hold = hd; rst = rs;
        @(negedge clk);
        model_cycle(st, hd, rs);
        got = sample(raw);
    endtask

    task automatic do_reset;
        tick(0, 0, 1, 1);
        tick(0, 0, 1, 1);
        tick(0, 0, 0, 1);
    endtask

    task automatic test_reset;
        set_cfg(0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(0, i[0], 0, 1);
            total++;
            if (got !== exp_o) begin
                $display("FAIL reset_state i=%0d got=%h want=%h", i, got, exp_o); bad++;
            end
        end
    endtask

    task automatic test_full_run;
        int done_t = -1, ov_n = 0, ov_first = -1, ov_last_idx = -1;
        set_cfg(0);
        do_reset();
        for (int t = 0; t < 3300; t++) begin
            tick(t == 0, 0, 0, 0);
            total++;
            if (got !== exp_o) begin
                $display("FAIL full_run t=%0d got=%h want=%h", t, got, exp_o); bad++; break;
            end
            if (got.ov) begin ov_n++; ov_last_idx = int'(got.oidx); if (ov_first < 0) ov_first = t; end
            if (got.done) done_t = t;
            if (done_t >= 0 && t >= done_t + 2) break;
        end
        total += 4;
        if (done_t !== DONE_T) begin $display("FAIL full_done_cycle got=%0d want=%0d", done_t, DONE_T); bad++; end
        if (ov_n !== 120) begin $display("FAIL full_ov_count got=%0d want=120", ov_n); bad++; end
        if (ov_first !== 28 + BIAS) begin $display("FAIL full_first_ov got=%0d want=%0d", ov_first, 28 + BIAS); bad++; end
        if (ov_last_idx !== 119) begin $display("FAIL full_last_idx got=%0d want=119", ov_last_idx); bad++; end
    endtask

    task automatic test_hold;
        int done_t = -1, addr15 = -1;
        set_cfg(0);
        do_reset();
        for (int t = 0; t < 3300; t++) begin
            tick(t == 0, (t >= 10 && t <= 14), 0, 0);
            total++;
            if (got !== exp_o) begin
                $display("FAIL hold t=%0d got=%h want=%h", t, got, exp_o); bad++; break;
            end
            if (t == 15) addr15 = int'(got.addr);
            if (got.done) done_t = t;
            if (done_t >= 0 && t >= done_t + 2) break;
        end
        total += 2;
        if (addr15 !== 9) begin $display("FAIL hold_resume_addr got=%0d want=9", addr15); bad++; end
        if (done_t !== DONE_T + 5) begin $display("FAIL hold_done_cycle got=%0d want=%0d", done_t, DONE_T + 5); bad++; end
    endtask

    task automatic test_start_ignored;
        int done_t = -1, done_n = 0;
        set_cfg(0);
        do_reset();
        for (int t = 0; t < 3300; t++) begin
            tick(t == 0 || t == 500 || t == 3004, 0, 0, 0);
            total++;
            if (got !== exp_o) begin
                $display("FAIL start_ignored t=%0d got=%h want=%h", t, got, exp_o); bad++; break;
            end
            if (got.done) begin done_n++; done_t = t; end
            if (done_t >= 0 && t >= done_t + 6) break;
        end
        total += 2;
        if (done_n !== 1) begin $display("FAIL start_ignored_dones got=%0d want=1", done_n); bad++; end
        if (done_t !== DONE_T) begin $display("FAIL start_ignored_done got=%0d want=%0d", done_t, DONE_T); bad++; end
    endtask

    task automatic test_reset_midrun;
        int done_t = -1, addr_restart = -1;
        set_cfg(0);
        do_reset();
        for (int t = 0; t < 4800; t++) begin
            tick(t == 0 || t == 1510, 0, t == 1500, (t > 1500 && t < 1510));
            total++;
            if (got !== exp_o) begin
                $display("FAIL reset_midrun t=%0d got=%h want=%h", t, got, exp_o); bad++; break;
            end
            if (t == 1511) addr_restart = got.rd ? int'(got.addr) : -1;
            if (got.done) done_t = t;
            if (done_t >= 0 && t >= done_t + 2) break;
        end
        total += 2;
        if (addr_restart !== 0) begin $display("FAIL reset_restart_addr got=%0d want=0", addr_restart); bad++; end
        if (done_t !== 1510 + DONE_T) begin $display("FAIL reset_done_cycle got=%0d want=%0d", done_t, 1510 + DONE_T); bad++; end
    endtask

    task automatic test_small_cfg;
        int done_t = -1, mask_n = 0, max_addr = -1, stall;
        set_cfg(1);
        do_reset();
        for (int t = 0; t < 200; t++) begin
            tick(t == 0, (t > 0) && ($urandom_range(2) == 0), 0, 0);
            total++;
            if (got !== exp_o) begin
                $display("FAIL small_cfg t=%0d got=%h want=%h", t, got, exp_o); bad++; break;
            end
            if (got.mv && got.last && got.mask == 16'h000F) mask_n++;
            if (got.rd && int'(got.addr) > max_addr) max_addr = int'(got.addr);
            if (got.done) done_t = t;
            if (done_t >= 0 && t >= done_t + 2) break;
        end
        stall = m_stall;
        total += 3;
        if (mask_n !== 2) begin $display("FAIL small_last_mask got=%0d want=2", mask_n); bad++; end
        if (max_addr !== 2 * (2 + BIAS) - 1) begin $display("FAIL small_max_addr got=%0d want=%0d", max_addr, 2 * (2 + BIAS) - 1); bad++; end
        if (done_t !== 2 * (2 + BIAS) + 5 + stall) begin
            $display("FAIL small_done_cycle got=%0d want=%0d", done_t, 2 * (2 + BIAS) + 5 + stall); bad++;
        end
    endtask

    task automatic test_random_hold;
        int done_t = -1, stall;
        set_cfg(0);
        do_reset();
        for (int t = 0; t < 4500; t++) begin
            tick(t == 0 || (t < 2000 && $urandom_range(49) == 0), (t > 0) && ($urandom_range(7) == 0), 0, 0);
            total++;
            if (got !== exp_o) begin
                $display("FAIL random_hold t=%0d got=%h want=%h", t, got, exp_o); bad++; break;
            end
            if (got.done) done_t = t;
            if (done_t >= 0 && t >= done_t + 2) break;
        end
        stall = m_stall;
        total++;
        if (done_t !== DONE_T + stall) begin
            $display("FAIL random_done_cycle got=%0d want=%0d", done_t, DONE_T + stall); bad++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        test_reset();
        test_full_run();
        test_hold();
        test_start_ignored();
        test_reset_midrun();
        test_small_cfg();
        test_random_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
